// File: rtl/uart_host_loader.sv
`default_nettype none
// ============================================================================
// uart_host_loader : PC-side UART endpoint; streams a source RAM out LSB-first,
//                    then reassembles returned bytes into a capture RAM.
// Revision 1.0
// ============================================================================
module uart_host_loader #(
  parameter int MEM_WORD_LENGTH = 24,
  parameter int MEM_ADDR_LENGTH = 12,
  parameter int UART_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES  = 5_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [MEM_ADDR_LENGTH:0]   tx_word_count,
  input  logic [MEM_ADDR_LENGTH:0]   rx_word_count,
  output logic [MEM_ADDR_LENGTH-1:0] src_addr,
  input  logic [MEM_WORD_LENGTH-1:0] src_data,
  output logic [MEM_ADDR_LENGTH-1:0] cap_addr,
  output logic [MEM_WORD_LENGTH-1:0] cap_data,
  output logic                       cap_wr_en,
  input  logic                       txByteReady,
  output logic                       uartTxStart,
  output logic [UART_WIDTH-1:0]      byteToUart,
  input  logic                       new_rx_byte_indicate,
  input  logic [UART_WIDTH-1:0]      ByteFromUart,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout
);
  localparam int BYTES_PER_WORD = (MEM_WORD_LENGTH + UART_WIDTH - 1) / UART_WIDTH;
  localparam int SHW = BYTES_PER_WORD * UART_WIDTH;
  localparam int BIW = $clog2(BYTES_PER_WORD + 1);
  localparam int CW  = MEM_ADDR_LENGTH + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BIW-1:0] c_BYTE_LAST = BIW'(BYTES_PER_WORD - 1);
  localparam logic [TW-1:0]  c_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_LOAD      = 4'd2;
  localparam logic [3:0] S_SEND      = 4'd3;
  localparam logic [3:0] S_WAIT_ACK  = 4'd4;
  localparam logic [3:0] S_WAIT_IDLE = 4'd5;
  localparam logic [3:0] S_RECV      = 4'd6;
  localparam logic [3:0] S_WRITE     = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  logic [3:0]                 r_state, w_next;
  logic [CW-1:0]              r_tx_cnt, r_rx_cnt, r_tx_idx, r_rx_idx;
  logic [CW-1:0]              w_tx_idx_nx, w_rx_idx_nx;
  logic [BIW-1:0]             r_byte_idx;
  logic [SHW-1:0]             r_shift, r_asm;
  logic [TW-1:0]              r_to_cnt;
  logic                       r_timeout, r_cap_wr_en, r_done;
  logic [MEM_ADDR_LENGTH-1:0] r_cap_addr;
  logic [MEM_WORD_LENGTH-1:0] r_cap_data;
  logic                       w_byte_last, w_to_expire;

  assign w_tx_idx_nx = r_tx_idx + 1'b1;
  assign w_rx_idx_nx = r_rx_idx + 1'b1;
  assign w_byte_last = (r_byte_idx == c_BYTE_LAST);
  assign w_to_expire = (r_to_cnt == c_TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) begin
        if (tx_word_count != '0)      w_next = S_FETCH;
        else if (rx_word_count != '0) w_next = S_RECV;
        else                          w_next = S_DONE;
      end
      S_FETCH:    w_next = S_LOAD;
      S_LOAD:     w_next = S_SEND;
      S_SEND:     if (txByteReady)  w_next = S_WAIT_ACK;
      S_WAIT_ACK: if (!txByteReady) w_next = S_WAIT_IDLE;
      S_WAIT_IDLE: if (txByteReady) begin
        if (!w_byte_last)               w_next = S_SEND;
        else if (w_tx_idx_nx < r_tx_cnt) w_next = S_FETCH;
        else if (r_rx_cnt != '0)         w_next = S_RECV;
        else                             w_next = S_DONE;
      end
      S_RECV: begin
        if (new_rx_byte_indicate) begin
          if (w_byte_last) w_next = S_WRITE;
        end else if (w_to_expire) begin
          w_next = S_DONE;
        end
      end
      S_WRITE: w_next = (w_rx_idx_nx == r_rx_cnt) ? S_DONE : S_RECV;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    uartTxStart = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE, S_DONE: busy = 1'b0;
      S_SEND:         uartTxStart = txByteReady;
      default:        ;
    endcase
  end

  assign src_addr   = r_tx_idx[MEM_ADDR_LENGTH-1:0];
  assign byteToUart = r_shift[UART_WIDTH-1:0];
  assign cap_addr   = r_cap_addr;
  assign cap_data   = r_cap_data;
  assign cap_wr_en  = r_cap_wr_en;
  assign done       = r_done;
  assign timeout    = r_timeout;

  // Capture strobe and done are registered so each lands one cycle after its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_tx_idx    <= '0;
      r_rx_idx    <= '0;
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_asm       <= '0;
      r_to_cnt    <= '0;
      r_timeout   <= 1'b0;
      r_cap_wr_en <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_cap_wr_en <= 1'b0;
      r_done      <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: if (start) begin
          r_tx_cnt   <= tx_word_count;
          r_rx_cnt   <= rx_word_count;
          r_tx_idx   <= '0;
          r_rx_idx   <= '0;
          r_byte_idx <= '0;
          r_to_cnt   <= '0;
          r_timeout  <= 1'b0;
        end
        S_LOAD: r_shift <= SHW'(src_data);
        S_WAIT_IDLE: if (txByteReady) begin
          r_shift <= r_shift >> UART_WIDTH;
          if (w_byte_last) begin
            r_byte_idx <= '0;
            r_tx_idx   <= w_tx_idx_nx;
          end else begin
            r_byte_idx <= r_byte_idx + 1'b1;
          end
        end
        S_RECV: begin
          if (new_rx_byte_indicate) begin
            for (int b = 0; b < BYTES_PER_WORD; b++)
              if (r_byte_idx == BIW'(b)) r_asm[b*UART_WIDTH +: UART_WIDTH] <= ByteFromUart;
            r_byte_idx <= w_byte_last ? '0 : r_byte_idx + 1'b1;
            r_to_cnt   <= '0;
          end else if (w_to_expire) begin
            r_timeout <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          r_cap_wr_en <= 1'b1;
          r_cap_addr  <= r_rx_idx[MEM_ADDR_LENGTH-1:0];
          r_cap_data  <= r_asm[MEM_WORD_LENGTH-1:0];
          r_rx_idx    <= w_rx_idx_nx;
          r_to_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_host_loader.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for uart_host_loader: expected UART bytes and capture writes are
// queued from a word/byte reference model and checked by a free-running monitor.
module tb_uart_host_loader;
  localparam int MW = 24, AW = 12, UW = 8, TO = 100, BPW = 3;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW:0]   tx_word_count = '0, rx_word_count = '0;
  logic [AW-1:0] src_addr, cap_addr;
  logic [MW-1:0] src_data = '0, cap_data;
  logic          cap_wr_en, txByteReady, uartTxStart, busy, done, timeout;
  logic          new_rx_byte_indicate = 1'b0;
  logic [UW-1:0] byteToUart, ByteFromUart = '0;

  always #5 clk = ~clk;

  uart_host_loader #(.MEM_WORD_LENGTH(MW), .MEM_ADDR_LENGTH(AW), .UART_WIDTH(UW),
                     .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .tx_word_count(tx_word_count), .rx_word_count(rx_word_count),
    .src_addr(src_addr), .src_data(src_data),
    .cap_addr(cap_addr), .cap_data(cap_data), .cap_wr_en(cap_wr_en),
    .txByteReady(txByteReady), .uartTxStart(uartTxStart), .byteToUart(byteToUart),
    .new_rx_byte_indicate(new_rx_byte_indicate), .ByteFromUart(ByteFromUart),
    .busy(busy), .done(done), .timeout(timeout));

  // Source RAM with one-cycle read latency
  logic [MW-1:0] src_mem [0:(1<<AW)-1];
  always @(posedge clk) src_data <= src_mem[src_addr];

  // UART transmitter: goes busy for 10 cycles per launched byte
  int unsigned tx_busy_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      txByteReady <= 1'b1;
      tx_busy_cnt <= 0;
    end else if (uartTxStart) begin
      txByteReady <= 1'b0;
      tx_busy_cnt <= 10;
    end else if (tx_busy_cnt != 0) begin
      tx_busy_cnt <= tx_busy_cnt - 1;
      if (tx_busy_cnt == 1) txByteReady <= 1'b1;
    end
  end

  typedef struct { logic [AW-1:0] a; logic [MW-1:0] d; } cap_t;
  logic [UW-1:0] exp_tx[$];
  cap_t          exp_cap[$];
  int n_vec = 0, n_err = 0, tx_seen = 0, done_seen = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    logic prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (uartTxStart) begin
        tx_seen++;
        check("tx_handshake", {prev_start, txByteReady}, 2'b01);
        if (exp_tx.size() == 0) check("tx_unexpected_byte", {1'b1, byteToUart}, 9'h0);
        else check("tx_byte", byteToUart, exp_tx.pop_front());
      end
      prev_start = uartTxStart;
      if (cap_wr_en) begin
        if (exp_cap.size() == 0) check("cap_unexpected_write", {1'b1, cap_addr}, 13'h0);
        else begin
          cap_t e = exp_cap.pop_front();
          check("cap_write", {cap_addr, cap_data}, {e.a, e.d});
        end
      end
      if (done) done_seen++;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int tx, input int rx);
    tx_word_count = (AW+1)'(tx);
    rx_word_count = (AW+1)'(rx);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference: a word leaves as BPW bytes, least significant first
  task automatic push_tx_word(input logic [MW-1:0] w);
    for (int b = 0; b < BPW; b++) exp_tx.push_back(UW'(w >> (UW*b)));
  endtask

  task automatic send_rx(input logic [UW-1:0] v, input int gap);
    repeat (gap) tick();
    new_rx_byte_indicate = 1'b1;
    ByteFromUart = v;
    tick();
    new_rx_byte_indicate = 1'b0;
  endtask

  // Feed one word as bytes and queue the capture write it must produce
  task automatic send_rx_word(input int addr, input logic [UW*BPW-1:0] bytes);
    cap_t e;
    e.a = AW'(addr);
    e.d = MW'(bytes);
    exp_cap.push_back(e);
    for (int b = 0; b < BPW; b++) send_rx(bytes[UW*b +: UW], $urandom_range(1, 20));
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_seen;
    int k = 0;
    while (done_seen == d0 && k < budget) begin tick(); k++; end
    repeat (3) tick();
    check(name, done_seen - d0, 1);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int k = 0;
    while (tx_seen < target && k < budget) begin tick(); k++; end
    check("tx_count_reached", tx_seen >= target, 1);
  endtask

  initial begin
    int t0, k;
    logic [MW-1:0] w;
    logic [UW*BPW-1:0] bl;
    fork monitor(); join_none
    repeat (3) tick();
    check("reset_outputs", {uartTxStart, cap_wr_en, busy, done, timeout, src_addr,
                            cap_addr, cap_data, byteToUart}, 64'h0);
    rst = 1'b0;
    tick();

    // Two words out, rx=0; a start while busy must be ignored
    src_mem[0] = 24'h123456;
    src_mem[1] = 24'hABCDEF;
    push_tx_word(24'h123456);
    push_tx_word(24'hABCDEF);
    t0 = tx_seen;
    do_start(2, 0);
    check("busy_after_start", {busy, src_addr}, {1'b1, 12'h0});
    repeat (3) tick();
    do_start(5, 5);
    wait_done("tx2_done", 400);
    check("tx2_pulses", tx_seen - t0, 6);
    check("tx2_queue_empty", exp_tx.size(), 0);
    check("tx2_timeout", timeout, 0);

    // Receive three words, tx=0
    do_start(0, 3);
    send_rx_word(0, 24'h000001);
    send_rx_word(1, 24'h000002);
    send_rx_word(2, 24'hFFFFFF);
    wait_done("rx3_done", 200);
    check("rx3_queue_empty", exp_cap.size(), 0);

    // Receiver garbage during TX must be ignored
    w = MW'($urandom);
    src_mem[0] = w;
    push_tx_word(w);
    t0 = tx_seen;
    do_start(1, 1);
    k = 0;
    while (tx_seen < t0 + BPW && k < 200) begin
      new_rx_byte_indicate = 1'($urandom_range(0, 1));
      ByteFromUart = UW'($urandom);
      tick();
      k++;
    end
    new_rx_byte_indicate = 1'b0;
    repeat (20) tick();
    send_rx_word(0, (UW*BPW)'($urandom));
    wait_done("garbage_done", 200);
    check("garbage_queues_empty", exp_tx.size() + exp_cap.size(), 0);

    // Randomized load/unload rounds
    for (int it = 0; it < 4; it++) begin
      int ntx = $urandom_range(1, 4);
      int nrx = $urandom_range(1, 3);
      for (int i = 0; i < ntx; i++) begin
        w = MW'($urandom);
        src_mem[i] = w;
        push_tx_word(w);
      end
      t0 = tx_seen;
      do_start(ntx, nrx);
      wait_tx(t0 + BPW*ntx, 100*ntx);
      repeat (20) tick();
      for (int i = 0; i < nrx; i++) send_rx_word(i, (UW*BPW)'($urandom));
      wait_done("rand_done", 200);
      check("rand_queues_empty", exp_tx.size() + exp_cap.size(), 0);
    end

    // Timeout: rx=2 but only four bytes arrive
    do_start(0, 2);
    send_rx_word(0, 24'hC0FFEE);
    send_rx(8'h55, 2);
    k = 0;
    while (!done && k < 300) begin @(negedge clk); k++; end
    check("timeout_latency_ok", (k >= 90 && k <= 110), 1);
    check("timeout_flag", timeout, 1);
    repeat (5) tick();
    check("timeout_queue_empty", exp_cap.size(), 0);

    // Reset after the third byte, then a clean rerun from word 0
    for (int i = 0; i < 3; i++) src_mem[i] = MW'($urandom);
    for (int i = 0; i < 3; i++) push_tx_word(src_mem[i]);
    t0 = tx_seen;
    do_start(3, 0);
    check("timeout_cleared", timeout, 0);
    wait_tx(t0 + 3, 200);
    rst = 1'b1;
    #1;
    check("midreset_outputs", {uartTxStart, cap_wr_en, busy, done, timeout, src_addr,
                               cap_addr, cap_data, byteToUart}, 64'h0);
    exp_tx.delete();
    repeat (3) tick();
    rst = 1'b0;
    t0 = tx_seen;
    repeat (30) tick();
    check("no_tx_after_reset", tx_seen - t0, 0);
    for (int i = 0; i < 3; i++) push_tx_word(src_mem[i]);
    do_start(3, 0);
    wait_done("rerun_done", 600);
    check("rerun_pulses", tx_seen - t0, 9);
    check("rerun_queue_empty", exp_tx.size(), 0);

    // Empty transfer: done two cycles after start
    do_start(0, 0);
    k = 1;
    @(negedge clk);
    while (!done && k < 10) begin @(negedge clk); k++; end
    check("empty_done_latency", k, 2);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1);
  end
endmodule
`default_nettype wire
